// File: rtl/motoro3_step_ramp_ctrl.sv
// motoro3_step_ramp_ctrl: ramps lcStep toward a target and applies shadowed pwmLen/pwmMin, updating only at PWM period ends
module motoro3_step_ramp_ctrl #(
    parameter logic [3:0] STEP_MAX    = 4'd15,
    parameter int         DWELL_W     = 16,
    parameter logic [7:0] PWM_LEN_DEF = 8'd200,
    parameter logic [7:0] PWM_MIN_DEF = 8'd20
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               rcEnable,
    input  logic [3:0]         rcTargetStep,
    input  logic [DWELL_W-1:0] rcDwell,
    input  logic [7:0]         rcPwmLenIn,
    input  logic [7:0]         rcPwmMinIn,
    input  logic               rcLoad,
    input  logic               rcCycleEnd,
    output logic [7:0]         pwmLen,
    output logic [7:0]         pwmMin,
    output logic [3:0]         lcStep,
    output logic               rcUpdate,
    output logic               rcBusy,
    output logic               rcAtTarget,
    output logic [1:0]         rcState
);
    typedef enum logic [1:0] {IDLE = 2'b00, RAMP_UP = 2'b01, RAMP_DOWN = 2'b10, HOLD = 2'b11} state_t;
    localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
    state_t state, state_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt, cnt_inc, dwell_eff;
    logic [3:0] tgt, step_nxt;
    logic [7:0] sh_len, sh_min, len_nxt, min_nxt;
    logic pend, apply, tick;
    assign tgt       = rcEnable ? (rcTargetStep > STEP_MAX ? STEP_MAX : rcTargetStep) : 4'd0;
    assign dwell_eff = (rcDwell == '0) ? ONE : rcDwell;
    assign cnt_inc   = cnt + ONE;
    // >= rather than == so a dwell shortened mid-step still releases the step
    assign tick      = cnt_inc >= dwell_eff;
    assign apply     = rcCycleEnd && pend;
    assign len_nxt   = apply ? sh_len : pwmLen;
    assign min_nxt   = apply ? sh_min : pwmMin;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_nxt  = lcStep;
        case (state)
            IDLE: if (tgt != 4'd0) begin
                state_nxt = RAMP_UP;
                cnt_nxt   = '0;
            end
            RAMP_UP: if (tgt == lcStep) state_nxt = (tgt == 4'd0) ? IDLE : HOLD;
            else if (tgt < lcStep) begin
                state_nxt = RAMP_DOWN;
                cnt_nxt   = '0;
            end else if (rcCycleEnd) begin
                cnt_nxt  = tick ? '0 : cnt_inc;
                step_nxt = (tick && lcStep < STEP_MAX) ? lcStep + 4'd1 : lcStep;
            end
            RAMP_DOWN: if (tgt == lcStep) state_nxt = (tgt == 4'd0) ? IDLE : HOLD;
            else if (tgt > lcStep) begin
                state_nxt = RAMP_UP;
                cnt_nxt   = '0;
            end else if (rcCycleEnd) begin
                cnt_nxt  = tick ? '0 : cnt_inc;
                step_nxt = (tick && lcStep != 4'd0) ? lcStep - 4'd1 : lcStep;
            end
            HOLD: if (tgt != lcStep) begin
                state_nxt = (tgt > lcStep) ? RAMP_UP : RAMP_DOWN;
                cnt_nxt   = '0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= IDLE;
            cnt      <= '0;
            lcStep   <= 4'd0;
            pwmLen   <= PWM_LEN_DEF;
            pwmMin   <= PWM_MIN_DEF;
            sh_len   <= PWM_LEN_DEF;
            sh_min   <= PWM_MIN_DEF;
            pend     <= 1'b0;
            rcUpdate <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            lcStep   <= step_nxt;
            pwmLen   <= len_nxt;
            pwmMin   <= min_nxt;
            // a load coinciding with a period end is kept pending for the following period end
            sh_len   <= rcLoad ? rcPwmLenIn : sh_len;
            sh_min   <= rcLoad ? (rcPwmMinIn > rcPwmLenIn ? rcPwmLenIn : rcPwmMinIn) : sh_min;
            pend     <= rcLoad ? 1'b1 : (apply ? 1'b0 : pend);
            rcUpdate <= (len_nxt != pwmLen) || (min_nxt != pwmMin) || (step_nxt != lcStep);
        end
    end
    assign rcBusy     = (state == RAMP_UP) || (state == RAMP_DOWN);
    assign rcAtTarget = (state == HOLD);
    assign rcState    = state;
endmodule

// File: tb/tb_motoro3_step_ramp_ctrl.sv
// tb_motoro3_step_ramp_ctrl: vector table, directed ramp/reset sequences and a randomized run against a rule-level model
module tb_motoro3_step_ramp_ctrl;
    logic clk, nRst, rcEnable, rcLoad, rcCycleEnd;
    logic [3:0] rcTargetStep;
    logic [15:0] rcDwell;
    logic [7:0] rcPwmLenIn, rcPwmMinIn;
    logic [7:0] pwmLen, pwmMin;
    logic [3:0] lcStep;
    logic rcUpdate, rcBusy, rcAtTarget;
    logic [1:0] rcState;
    int n_chk = 0, n_fail = 0;

    motoro3_step_ramp_ctrl #(.STEP_MAX(4'd10)) dut (
        .clk(clk), .nRst(nRst), .rcEnable(rcEnable), .rcTargetStep(rcTargetStep),
        .rcDwell(rcDwell), .rcPwmLenIn(rcPwmLenIn), .rcPwmMinIn(rcPwmMinIn),
        .rcLoad(rcLoad), .rcCycleEnd(rcCycleEnd), .pwmLen(pwmLen), .pwmMin(pwmMin),
        .lcStep(lcStep), .rcUpdate(rcUpdate), .rcBusy(rcBusy), .rcAtTarget(rcAtTarget),
        .rcState(rcState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic en; logic [3:0] tg; logic [15:0] dw; logic ld; logic [7:0] li, mi; logic ce;
        logic [7:0] e_len, e_min; logic [3:0] e_step; logic [1:0] e_st; logic e_upd;
    } vec_t;
    vec_t tv[$];

    // reference model state, expressed in terms of the observable rules
    int m_len, m_min, m_step, m_mode, m_cnt, m_shl, m_shm, m_pend, m_upd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rcEnable = 0; rcTargetStep = 0; rcDwell = 1; rcPwmLenIn = 0; rcPwmMinIn = 0;
        rcLoad = 0; rcCycleEnd = 0;
    endtask

    task automatic do_reset();
        clr_in();
        nRst = 0;
        repeat (2) @(posedge clk);
        #1 nRst = 1;
    endtask

    task automatic model_reset();
        m_len = 200; m_min = 20; m_step = 0; m_mode = 0; m_cnt = 0;
        m_shl = 200; m_shm = 20; m_pend = 0; m_upd = 0;
    endtask

    task automatic model_step();
        int t, d, ol, om, os, dw;
        ol = m_len; om = m_min; os = m_step;
        t = rcEnable ? (rcTargetStep > 10 ? 10 : int'(rcTargetStep)) : 0;
        d = t - m_step;
        dw = (rcDwell == 0) ? 1 : int'(rcDwell);
        if (rcCycleEnd && m_pend != 0) begin
            m_len = m_shl; m_min = m_shm; m_pend = 0;
        end
        if (rcLoad) begin
            m_shl = rcPwmLenIn;
            m_shm = (rcPwmMinIn > rcPwmLenIn) ? int'(rcPwmLenIn) : int'(rcPwmMinIn);
            m_pend = 1;
        end
        if (m_mode == 0) begin
            if (t > 0) begin m_mode = 1; m_cnt = 0; end
        end else if (d == 0) m_mode = (t == 0) ? 0 : 3;
        else if (m_mode == 3 || (m_mode == 1 && d < 0) || (m_mode == 2 && d > 0)) begin
            m_mode = (d > 0) ? 1 : 2; m_cnt = 0;
        end else if (rcCycleEnd) begin
            m_cnt++;
            if (m_cnt >= dw) begin
                m_step += (d > 0) ? 1 : -1;
                m_cnt = 0;
            end
        end
        m_upd = (ol != m_len || om != m_min || os != m_step) ? 1 : 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".len"}, pwmLen, m_len);
        chk({tag, ".min"}, pwmMin, m_min);
        chk({tag, ".step"}, lcStep, m_step);
        chk({tag, ".state"}, rcState, m_mode);
        chk({tag, ".upd"}, rcUpdate, m_upd);
        chk({tag, ".busy"}, rcBusy, (m_mode == 1 || m_mode == 2) ? 1 : 0);
        chk({tag, ".attgt"}, rcAtTarget, (m_mode == 3) ? 1 : 0);
    endtask

    task automatic pulse_ce(input int idle);
        repeat (idle) cyc();
        rcCycleEnd = 1;
        cyc();
        rcCycleEnd = 0;
    endtask

    initial begin
        int upd_cnt;
        // en tg dw ld li mi ce | len min step st upd
        tv.push_back('{0, 0, 1, 0,   0,   0, 0, 200,  20, 0, 0, 0});
        tv.push_back('{0, 0, 1, 1, 100, 150, 0, 200,  20, 0, 0, 0});
        tv.push_back('{0, 0, 1, 0,   0,   0, 1, 100, 100, 0, 0, 1});
        tv.push_back('{0, 0, 1, 0,   0,   0, 0, 100, 100, 0, 0, 0});
        tv.push_back('{0, 0, 1, 1,  50,  10, 1, 100, 100, 0, 0, 0});
        tv.push_back('{0, 0, 1, 0,   0,   0, 1,  50,  10, 0, 0, 1});
        tv.push_back('{1, 2, 1, 0,   0,   0, 0,  50,  10, 0, 1, 0});
        tv.push_back('{1, 2, 1, 0,   0,   0, 1,  50,  10, 1, 1, 1});
        tv.push_back('{1, 2, 1, 1,  80,  30, 1,  50,  10, 2, 1, 1});
        tv.push_back('{1, 2, 1, 0,   0,   0, 0,  50,  10, 2, 3, 0});
        tv.push_back('{1, 2, 1, 0,   0,   0, 1,  80,  30, 2, 3, 1});
        tv.push_back('{0, 2, 1, 0,   0,   0, 0,  80,  30, 2, 2, 0});
        tv.push_back('{0, 2, 1, 0,   0,   0, 1,  80,  30, 1, 2, 1});
        tv.push_back('{0, 2, 1, 0,   0,   0, 1,  80,  30, 0, 2, 1});
        tv.push_back('{0, 2, 1, 0,   0,   0, 0,  80,  30, 0, 0, 0});
        tv.push_back('{1, 15, 1, 0,  0,   0, 0,  80,  30, 0, 1, 0});
        tv.push_back('{1, 15, 1, 0,  0,   0, 1,  80,  30, 1, 1, 1});

        // reset defaults and quiet run
        do_reset();
        chk("rst.len", pwmLen, 200);
        chk("rst.min", pwmMin, 20);
        chk("rst.step", lcStep, 0);
        chk("rst.state", rcState, 0);
        upd_cnt = 0;
        repeat (20) begin cyc(); upd_cnt += rcUpdate; end
        chk("quiet.upd", upd_cnt, 0);
        chk("quiet.len", pwmLen, 200);

        // vector table
        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            rcEnable = tv[i].en; rcTargetStep = tv[i].tg; rcDwell = tv[i].dw;
            rcLoad = tv[i].ld; rcPwmLenIn = tv[i].li; rcPwmMinIn = tv[i].mi; rcCycleEnd = tv[i].ce;
            cyc();
            chk($sformatf("vec%0d.len", i), pwmLen, tv[i].e_len);
            chk($sformatf("vec%0d.min", i), pwmMin, tv[i].e_min);
            chk($sformatf("vec%0d.step", i), lcStep, tv[i].e_step);
            chk($sformatf("vec%0d.state", i), rcState, tv[i].e_st);
            chk($sformatf("vec%0d.upd", i), rcUpdate, tv[i].e_upd);
        end
        clr_in();

        // ramp up to 3 with dwell 2, period of 10 clocks
        do_reset();
        rcEnable = 1; rcTargetStep = 3; rcDwell = 2;
        upd_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            repeat (9) begin cyc(); upd_cnt += rcUpdate; end
            rcCycleEnd = 1; cyc(); upd_cnt += rcUpdate; rcCycleEnd = 0;
            chk($sformatf("up.step%0d", k), lcStep, k / 2);
            if (k < 6) chk($sformatf("up.state%0d", k), rcState, 1);
        end
        cyc(); upd_cnt += rcUpdate;
        chk("up.hold", rcState, 3);
        chk("up.attgt", rcAtTarget, 1);
        chk("up.busy", rcBusy, 0);
        chk("up.updcnt", upd_cnt, 3);

        // ramp down to idle with dwell 1
        rcEnable = 0; rcDwell = 1;
        cyc();
        chk("dn.state", rcState, 2);
        for (int k = 1; k <= 3; k++) begin
            pulse_ce(9);
            chk($sformatf("dn.step%0d", k), lcStep, 3 - k);
        end
        cyc();
        chk("dn.idle", rcState, 0);

        // clamped target with dwell 0
        do_reset();
        rcEnable = 1; rcTargetStep = 4'hF; rcDwell = 0;
        for (int k = 1; k <= 12; k++) begin
            pulse_ce(2);
            chk($sformatf("clamp.step%0d", k), lcStep, k > 10 ? 10 : k);
        end
        chk("clamp.hold", rcState, 3);

        // asynchronous reset in the middle of a ramp
        do_reset();
        rcEnable = 1; rcTargetStep = 8; rcDwell = 0;
        rcLoad = 1; rcPwmLenIn = 90; rcPwmMinIn = 40;
        pulse_ce(1);
        rcLoad = 0;
        for (int k = 2; k <= 5; k++) pulse_ce(1);
        chk("arst.pre_step", lcStep, 5);
        chk("arst.pre_len", pwmLen, 90);
        chk("arst.pre_state", rcState, 1);
        #2 nRst = 0;
        #1;
        chk("arst.step", lcStep, 0);
        chk("arst.len", pwmLen, 200);
        chk("arst.min", pwmMin, 20);
        chk("arst.state", rcState, 0);
        chk("arst.busy", rcBusy, 0);
        @(posedge clk); #1 nRst = 1;
        pulse_ce(1);
        chk("arst.restep", lcStep, 1);
        chk("arst.relen", pwmLen, 200);

        // randomized run against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                rcEnable = ($urandom_range(0, 3) != 0);
                rcTargetStep = 4'($urandom_range(0, 15));
                rcDwell = 16'($urandom_range(0, 3));
            end
            rcLoad = ($urandom_range(0, 9) == 0);
            rcPwmLenIn = 8'($urandom_range(0, 255));
            rcPwmMinIn = 8'($urandom_range(0, 255));
            rcCycleEnd = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 599) == 0) begin
                nRst = 0;
                #2;
                model_reset();
                check_model("rnd.rst");
                nRst = 1;
            end
            @(posedge clk);
            model_step();
            #1;
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
